button_event_decoder: RTL

//  Consumer end of the debounced-switch path: takes one clean, debounced button level and

---
 rtl/button_event_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns one debounced button level into single-cycle events (press, release,
//   long-press, auto-repeat) and a held level. Timing is counted in 'enable'
//   ticks from the shared prescaler. All outputs are registered, so each event
//   appears one clk after the edge that samples its cause.
//
// Ports
//   clk            in   system clock, posedge
//   reset          in   synchronous, active-high reset
//   enable         in   one-clk prescaler tick; the counter advances only on it
//   btn_level      in   debounced level, 1 = pressed
//   press_pulse    out  1-clk pulse on an accepted 0->1 transition
//   release_pulse  out  1-clk pulse on a 1->0 transition while a press is active
//   long_pulse     out  1-clk pulse once the press has lasted LONG_TICKS ticks
//   repeat_pulse   out  1-clk pulse every REPEAT_TICKS ticks after long_pulse
//   held           out  1 while a press is active (PRESSED or LONG)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no press active; waiting for a rising edge of btn_level
// PRESSED | press accepted; counting ticks toward LONG_TICKS
// LONG    | long-press reached; counting ticks toward each repeat
module button_event_decoder #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             rise, fall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_d     = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    rise = btn_level & ~btn_q;
    fall = ~btn_level & btn_q;

    case (state_q)
      IDLE: begin
        // enable is ignored here, so a tick coinciding with the rise is not counted
        if (rise) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        // fall has priority: a tick arriving with the release is dropped
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (enable) begin
          if (cnt_q == LONG_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (enable) begin
          if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      // Treat the button as already pressed so a button held through reset
      // must be released and pressed again before it produces a press.
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
